// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-style bus between instruction fetch (IF) and data access (MEM).
// Data has fixed priority. Define MEM_ARB_TIMEOUT_EN to add the bus watchdog and error pulses.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stallreq,
    input  logic              d_en,
    input  logic [3:0]        d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_stall,
    input  logic              d_flush,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stallreq,
    output logic              bus_req,
    output logic [3:0]        bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              i_err,
    output logic              d_err
);

    typedef enum logic [1:0] {
        StIdle,
        StDBusy,
        StIBusy
    } state_e;

    state_e state_q;
    logic   i_done_q;
    logic   d_done_q;
    logic   discard_q;
    logic   i_need;
    logic   d_need;
    logic   tmo_hit;
    logic   busy_end;
    logic   i_end;
    logic   d_end;
    logic   i_set;
    logic   d_set;
    logic   own_flush;

    if (TMO_CYCLES == 0) begin : g_bad_tmo
        $error("mem_arbiter: TMO_CYCLES must be nonzero");
    end

    assign i_need     = i_en & ~i_done_q;
    assign d_need     = d_en & ~d_done_q;
    assign i_stallreq = i_need;
    assign d_stallreq = d_need;

    assign busy_end  = (state_q != StIdle) & (bus_ack | tmo_hit);
    assign d_end     = busy_end & (state_q == StDBusy);
    assign i_end     = busy_end & (state_q == StIBusy);
    assign own_flush = ((state_q == StDBusy) & d_flush) | ((state_q == StIBusy) & i_flush);

    // A flush landing on the completion cycle discards the result like an earlier one.
    assign d_set = d_end & ~discard_q & ~d_flush;
    assign i_set = i_end & ~discard_q & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            discard_q <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            // Set wins over the advance/flush clear: the stage is held by its own stallreq.
            d_done_q <= d_set | (d_done_q & d_stall & ~d_flush);
            i_done_q <= i_set | (i_done_q & i_stall & ~i_flush);

            unique case (state_q)
                StIdle: begin
                    discard_q <= 1'b0;
                    if (d_need) begin
                        bus_req   <= 1'b1;
                        bus_addr  <= d_addr;
                        bus_wr    <= d_wr;
                        bus_wdata <= d_wdata;
                        state_q   <= StDBusy;
                    end else if (i_need) begin
                        bus_req  <= 1'b1;
                        bus_addr <= i_addr;
                        bus_wr   <= '0;
                        state_q  <= StIBusy;
                    end
                end
                StDBusy, StIBusy: begin
                    if (busy_end) begin
                        if ((state_q == StIBusy) && bus_ack) begin
                            i_rdata <= bus_rdata;
                        end
                        if ((state_q == StDBusy) && bus_ack && (bus_wr == 4'b0000)) begin
                            d_rdata <= bus_rdata;
                        end
                        bus_req   <= 1'b0;
                        bus_wr    <= '0;
                        discard_q <= 1'b0;
                        state_q   <= StIdle;
                    end else if (own_flush) begin
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Counter only needs to reach TMO_CYCLES-1; it is zero on the first BUSY cycle.
    localparam int unsigned CntW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

    logic [CntW-1:0] tmo_cnt_q;

    assign tmo_hit = (state_q != StIdle) & ~bus_ack & (tmo_cnt_q == CntW'(TMO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            if ((state_q == StIdle) || busy_end) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CntW'(1);
            end
            i_err <= tmo_hit & (state_q == StIBusy);
            d_err <= tmo_hit & (state_q == StDBusy);
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign i_err   = 1'b0;
    assign d_err   = 1'b0;
`endif

endmodule
